// File: rtl/bp_stall_counter_reader.sv
// Snapshot reader for the core stall/instruction counter bank; streams a
// framed, atomically sampled copy of all counters over ready/valid.
//
// Ports:
//   clk_i, reset_n_i      clock, async active-low reset
//   counters_i            flat bank, counter k at [k*width_p +: width_p]
//   req_v_i/req_ready_o   snapshot request handshake
//   data_o/v_o/ready_i    output word stream
//   last_o                final word of a frame (qualified by v_o)
//   seq_o                 sequence number of the next frame to emit
//   dropped_o             saturating count of request cycles seen while busy
//
// Optional feature macro: BP_STALL_READER_CHECKSUM_EN appends an XOR
// checksum word (header ^ all counters) carrying last_o.
module bp_stall_counter_reader #(
   parameter int width_p            = 32,
   parameter int num_counters_p     = 36,
   parameter int lg_num_counters_lp =
      (num_counters_p > 1) ? $clog2(num_counters_p) : 1
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [num_counters_p*width_p-1:0] counters_i,
   input  logic                              req_v_i,
   output logic                              req_ready_o,
   output logic [width_p-1:0]                data_o,
   output logic                              v_o,
   input  logic                              ready_i,
   output logic                              last_o,
   output logic [7:0]                        seq_o,
   output logic [width_p-1:0]                dropped_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HDR   = 2'd1,
      DATA  = 2'd2
`ifdef BP_STALL_READER_CHECKSUM_EN
      ,CKSUM = 2'd3
`endif
   } state_e;

   localparam logic [7:0] num_lp = 8'(num_counters_p);
   localparam logic [lg_num_counters_lp-1:0] idx_last_lp =
      lg_num_counters_lp'(num_counters_p - 1);

   state_e                        state_r, state_n;
   logic [lg_num_counters_lp-1:0] idx_r, idx_n;
   logic [7:0]                    seq_r, seq_n;
   logic [width_p-1:0]            dropped_r;
   logic [width_p-1:0]            snap_r [num_counters_p];
   logic [width_p-1:0]            hdr;
   logic                          at_end;

   assign at_end    = (idx_r == idx_last_lp);
   assign seq_o     = seq_r;
   assign dropped_o = dropped_r;

   always_comb begin
      hdr       = '0;
      hdr[31:0] = {16'hC5A7, seq_r, num_lp};
   end

`ifdef BP_STALL_READER_CHECKSUM_EN
   logic [width_p-1:0] cksum;

   always_comb begin
      cksum = hdr;
      for (int k = 0; k < num_counters_p; k++)
         cksum = cksum ^ snap_r[k];
   end
`endif

   always_comb begin
      state_n     = state_r;
      idx_n       = idx_r;
      seq_n       = seq_r;
      req_ready_o = 1'b0;
      v_o         = 1'b0;
      last_o      = 1'b0;
      data_o      = '0;
      unique case (state_r)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_v_i) state_n = HDR;
         end
         HDR: begin
            v_o    = 1'b1;
            data_o = hdr;
            if (ready_i) begin
               idx_n   = '0;
               state_n = DATA;
            end
         end
         DATA: begin
            v_o    = 1'b1;
            data_o = snap_r[idx_r];
`ifdef BP_STALL_READER_CHECKSUM_EN
            if (ready_i) begin
               if (at_end) state_n = CKSUM;
               else        idx_n   = idx_r + 1'b1;
            end
`else
            last_o = at_end;
            if (ready_i) begin
               if (at_end) begin
                  seq_n   = seq_r + 8'd1;
                  state_n = IDLE;
               end else begin
                  idx_n = idx_r + 1'b1;
               end
            end
`endif
         end
`ifdef BP_STALL_READER_CHECKSUM_EN
         CKSUM: begin
            v_o    = 1'b1;
            last_o = 1'b1;
            data_o = cksum;
            if (ready_i) begin
               seq_n   = seq_r + 8'd1;
               state_n = IDLE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= IDLE;
         idx_r   <= '0;
         seq_r   <= '0;
      end else begin
         state_r <= state_n;
         idx_r   <= idx_n;
         seq_r   <= seq_n;
      end
   end

   // Level-counted: every busy cycle with a request pending counts once.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         dropped_r <= '0;
      else if (state_r != IDLE && req_v_i && dropped_r != '1)
         dropped_r <= dropped_r + width_p'(1);
   end

   // Whole bank captured on the accept edge so a frame is one coherent sample.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int k = 0; k < num_counters_p; k++)
            snap_r[k] <= '0;
      end else if (req_v_i && req_ready_o) begin
         for (int k = 0; k < num_counters_p; k++)
            snap_r[k] <= counters_i[k*width_p +: width_p];
      end
   end

endmodule

// File: tb/tb_bp_stall_counter_reader.sv
// Scoreboard bench for bp_stall_counter_reader: frames predicted at accept
// time, checked word by word as the DUT hands them over.
module tb_bp_stall_counter_reader;

   localparam int W  = 32;
   localparam int NC = 4;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } word_t;

   logic            clk = 1'b0;
   logic            reset_n_i;
   logic [NC*W-1:0] counters_i;
   logic            req_v_i;
   logic            req_ready_o;
   logic [W-1:0]    data_o;
   logic            v_o;
   logic            ready_i;
   logic            last_o;
   logic [7:0]      seq_o;
   logic [W-1:0]    dropped_o;

   logic [W-1:0] cnt [NC];

   int tests  = 0;
   int fails  = 0;
   int frames = 0;

   word_t        exp_q[$];
   logic [7:0]   mseq  = 0;
   logic [W-1:0] mdrop = 0;
   logic         stall_prev = 0;
   logic [W-1:0] held_d;
   logic         held_l;

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NC; k++)
         counters_i[k*W +: W] = cnt[k];
   end

   bp_stall_counter_reader #(
      .width_p        (W),
      .num_counters_p (NC)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (reset_n_i),
      .counters_i  (counters_i),
      .req_v_i     (req_v_i),
      .req_ready_o (req_ready_o),
      .data_o      (data_o),
      .v_o         (v_o),
      .ready_i     (ready_i),
      .last_o      (last_o),
      .seq_o       (seq_o),
      .dropped_o   (dropped_o)
   );

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic push_frame();
      logic [W-1:0] h;
      logic [W-1:0] x;
      h = {16'hC5A7, mseq, 8'(NC)};
      exp_q.push_back('{d: h, l: 1'b0});
      x = h;
      for (int k = 0; k < NC; k++) begin
         x = x ^ cnt[k];
`ifdef BP_STALL_READER_CHECKSUM_EN
         exp_q.push_back('{d: cnt[k], l: 1'b0});
`else
         exp_q.push_back('{d: cnt[k], l: (k == NC - 1)});
`endif
      end
`ifdef BP_STALL_READER_CHECKSUM_EN
      exp_q.push_back('{d: x, l: 1'b1});
`endif
   endtask

   // Reference model + monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic  idle;
      word_t w;
      if (!reset_n_i) begin
         exp_q.delete();
         mseq       = 0;
         mdrop      = 0;
         stall_prev = 0;
      end else begin
         idle = (exp_q.size() == 0);
         chk("req_ready", W'(req_ready_o), W'(idle));
         chk("v_o", W'(v_o), W'(!idle));
         chk("seq_o", W'(seq_o), W'(mseq));
         chk("dropped_o", dropped_o, mdrop);
         if (stall_prev) begin
            chk("hold_data", data_o, held_d);
            chk("hold_last", W'(last_o), W'(held_l));
         end
         stall_prev = 0;
         if (v_o && !idle) begin
            if (ready_i) begin
               w = exp_q.pop_front();
               chk("word", data_o, w.d);
               chk("last", W'(last_o), W'(w.l));
               if (w.l) begin
                  mseq = mseq + 8'd1;
                  frames++;
               end
            end else begin
               stall_prev = 1;
               held_d     = data_o;
               held_l     = last_o;
            end
         end
         if (req_v_i) begin
            if (idle) push_frame();
            else if (mdrop != '1) mdrop = mdrop + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || v_o) && n < max) begin
         step();
         n++;
      end
      tests++;
      if (n >= max) begin
         fails++;
         $display("FAIL drain_timeout: got %0d words left expected 0",
                  exp_q.size());
      end
   endtask

   task automatic one_frame();
      req_v_i = 1;
      step();
      req_v_i = 0;
   endtask

   initial begin
      reset_n_i = 0;
      req_v_i   = 0;
      ready_i   = 0;
      for (int k = 0; k < NC; k++) cnt[k] = '0;
      repeat (3) step();
      chk("reset_v", W'(v_o), 0);
      chk("reset_data", data_o, 0);
      chk("reset_ready", W'(req_ready_o), 1);
      reset_n_i = 1;
      step();

      // Basic frame {40,30,20,10}.
      cnt[0] = 10; cnt[1] = 20; cnt[2] = 30; cnt[3] = 40;
      ready_i = 1;
      one_frame();
      drain(20);
      chk("seq_after1", W'(seq_o), 1);

      // Checksum-friendly frame {4,3,2,1}.
      cnt[0] = 1; cnt[1] = 2; cnt[2] = 3; cnt[3] = 4;
      one_frame();
      drain(20);

      // Atomicity under changing counters and toggled backpressure.
      one_frame();
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < NC; k++) cnt[k] = cnt[k] + 1;
         ready_i = ~ready_i;
         step();
      end
      ready_i = 1;
      drain(30);

      // Busy drops: 3 request cycles during an active frame.
      ready_i = 0;
      one_frame();
      step();
      req_v_i = 1;
      repeat (3) step();
      req_v_i = 0;
      ready_i = 1;
      drain(30);
      chk("dropped3", dropped_o, 3);

      // Random traffic until the sequence number has wrapped.
      for (int c = 0; c < 20000 && frames < 270; c++) begin
         req_v_i = ($urandom_range(0, 3) == 0);
         ready_i = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < NC; k++)
            cnt[k] = cnt[k] + W'($urandom_range(0, 5));
         step();
      end
      req_v_i = 0;
      ready_i = 1;
      drain(50);
      chk("frames_wrapped", W'(frames > 257), 1);

      // Async reset in the middle of a frame.
      one_frame();
      step();
      step();
      #1 reset_n_i = 0;
      #1;
      chk("rst_v_async", W'(v_o), 0);
      chk("rst_last_async", W'(last_o), 0);
      step();
      step();
      reset_n_i = 1;
      step();
      chk("rst_ready", W'(req_ready_o), 1);
      chk("rst_seq", W'(seq_o), 0);
      chk("rst_dropped", dropped_o, 0);
      one_frame();
      drain(20);
      chk("seq_after_rst", W'(seq_o), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
